// File: rtl/au_gray_ptr_arb_pkg.sv
// rtl/au_gray_ptr_arb_pkg.sv - shared constants and helper functions for the Gray pointer arbiter
package au_gray_ptr_arb_pkg;

  // Widest channel vector the helper functions operate on
  localparam int MAX_NCH = 16;

  // Gray code of the last binary count: MSB set, all other bits clear
  function automatic logic [31:0] gray_wrap_val(input int width);
    return 32'(1) << (width - 1);
  endfunction

  // Bits needed to hold a channel index (at least one)
  function automatic int idx_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

  // One-hot pick of the first eligible channel after 'last', wrapping modulo nch
  function automatic logic [MAX_NCH-1:0] rr_next_grant(input logic [MAX_NCH-1:0] elig,
                                                       input int last,
                                                       input int nch);
    logic [MAX_NCH-1:0] pick;
    int idx;
    pick = '0;
    for (int o = 1; o <= MAX_NCH; o++) begin
      idx = last + o;
      if (idx >= nch) idx = idx - nch;
      if ((o <= nch) && (pick == '0) && elig[idx[3:0]]) pick[idx[3:0]] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/au_inc_gray.sv
// rtl/au_inc_gray.sv - combinational Gray-code successor, two selectable architectures
module au_inc_gray #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_out
);

  generate
    if (ARCH == 0) begin : g_bin
      logic [WIDTH-1:0] bin;
      logic [WIDTH-1:0] binc;
      // Convert to binary, add one, convert back to Gray
      always_comb begin
        bin[WIDTH-1] = gray_in[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) bin[i] = bin[i+1] ^ gray_in[i];
        binc     = bin + WIDTH'(1);
        gray_out = binc ^ (binc >> 1);
      end
    end else begin : g_par
      logic par;
      int   low;
      // Parity rule: even parity flips bit 0, odd flips the bit left of the lowest set bit
      always_comb begin
        par = ^gray_in;
        low = WIDTH - 1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (gray_in[i]) low = i;
        end
        if (!par)                gray_out = gray_in ^ WIDTH'(1);
        else if (low == WIDTH-1) gray_out = gray_in ^ (WIDTH'(1) << (WIDTH - 1));
        else                     gray_out = gray_in ^ (WIDTH'(1) << (low + 1));
      end
    end
  endgenerate

endmodule

// File: rtl/au_gray_ptr_arb.sv
// rtl/au_gray_ptr_arb.sv - round-robin arbiter advancing per-channel Gray pointers through one shared incrementer (optional wrap output: AU_GRAY_PTR_ARB_WRAP_EN)
module au_gray_ptr_arb
  import au_gray_ptr_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int ARCH  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH-1:0]       clr,
  output logic [NCH-1:0]       gnt,
`ifdef AU_GRAY_PTR_ARB_WRAP_EN
  output logic [NCH-1:0]       wrap,
`endif
  output logic [NCH*WIDTH-1:0] ptr
);

  localparam int IW = idx_width(NCH);

  logic [WIDTH-1:0] ptr_r [NCH];
  logic [IW-1:0]    last;
  logic [NCH-1:0]   elig;
  logic [IW-1:0]    gidx;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] succ;

  // Round-robin grant over requesters not being cleared; suppressed during reset
  always_comb begin
    elig = req & ~clr;
    gnt  = NCH'(rr_next_grant(MAX_NCH'(elig), int'(last), NCH));
    if (rst) gnt = '0;
  end

  // Encode the grant and select that channel's pointer for the shared incrementer
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) gidx = IW'(i);
    end
    cur = ptr_r[gidx];
  end

  au_inc_gray #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_inc (
    .gray_in  (cur),
    .gray_out (succ)
  );

  // Pointer and last-grant state: clear wins, granted channel advances, others hold
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) ptr_r[i] <= '0;
      last <= IW'(NCH - 1);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i])      ptr_r[i] <= '0;
        else if (gnt[i]) ptr_r[i] <= succ;
      end
      if (|gnt) last <= gidx;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ptr
      assign ptr[g*WIDTH +: WIDTH] = ptr_r[g];
    end
  endgenerate

`ifdef AU_GRAY_PTR_ARB_WRAP_EN
  localparam logic [WIDTH-1:0] WRAP_VAL = WIDTH'(gray_wrap_val(WIDTH));

  // One-cycle pulse after a granted pointer steps from the wrap value back to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) wrap[i] <= gnt[i] && (ptr_r[i] == WRAP_VAL);
    end
  end
`endif

endmodule

// File: tb/tb_au_gray_ptr_arb.sv
// tb/tb_au_gray_ptr_arb.sv - directed and model-checked bench for au_gray_ptr_arb (WIDTH=4, NCH=4)
module tb_au_gray_ptr_arb;

  localparam int WIDTH = 4;
  localparam int NCH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  clr;
  logic [3:0]  gnt;
  logic [15:0] ptr;
`ifdef AU_GRAY_PTR_ARB_WRAP_EN
  logic [3:0]  wrap;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  au_gray_ptr_arb #(.WIDTH(WIDTH), .NCH(NCH), .ARCH(0)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .clr  (clr),
    .gnt  (gnt),
`ifdef AU_GRAY_PTR_ARB_WRAP_EN
    .wrap (wrap),
`endif
    .ptr  (ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; clr = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] seq [17];
  logic [3:0] gseq [8];

  // Reference model state for the random phase
  logic [3:0] mbin [4];
  int         mlast;
  logic [3:0] mgnt;
  logic [3:0] mwrap;
  logic [15:0] mptr;

  initial begin
    seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    gseq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};

    // Reset held three cycles with every channel requesting
    rst = 1'b1; req = 4'hF; clr = 4'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rst_gnt", 32'(gnt), 32'h0);
      tick();
    end
    check("rst_ptr", 32'(ptr), 32'h0);
`ifdef AU_GRAY_PTR_ARB_WRAP_EN
    check("rst_wrap", 32'(wrap), 32'h0);
`endif
    rst = 1'b0;
    #1;
    check("rst_first_gnt", 32'(gnt), 32'h1);

    // Single channel walks the full Gray sequence and wraps
    do_reset();
    req = 4'b0010;
    for (int k = 0; k <= 16; k++) begin
      #1;
      check("single_ptr", 32'(ptr), 32'(seq[k]) << 4);
`ifdef AU_GRAY_PTR_ARB_WRAP_EN
      check("single_wrap", 32'(wrap), (k == 16) ? 32'h2 : 32'h0);
`endif
      if (k < 16) begin
        check("single_gnt", 32'(gnt), 32'h2);
        tick();
      end
    end

    // All channels requesting: strict rotation
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_gnt", 32'(gnt), 32'(gseq[k]));
      tick();
    end
    check("rr_ptr", 32'(ptr), 32'h3333);

    // Reset pulse mid-run discards the in-cycle transfer
    check("mid_gnt0", 32'(gnt), 32'h1);
    tick();
    check("mid_gnt1", 32'(gnt), 32'h2);
    rst = 1'b1;
    #1;
    check("mid_gnt_rst", 32'(gnt), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_ptr", 32'(ptr), 32'h0);
    check("mid_restart", 32'(gnt), 32'h1);

    // Clear takes priority over request; next eligible after ch1 is ch3
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 4; k++) tick();
    req = 4'b0010;
    #1;
    check("clr_setup_gnt", 32'(gnt), 32'h2);
    tick();
    check("clr_setup_ptr", 32'(ptr), 32'h0610);
    req = 4'b1100; clr = 4'b0100;
    #1;
    check("clr_gnt", 32'(gnt), 32'h8);
    tick();
    req = 4'b0000; clr = 4'b0000;
    #1;
    check("clr_ptr", 32'(ptr), 32'h1010);
`ifdef AU_GRAY_PTR_ARB_WRAP_EN
    check("clr_wrap", 32'(wrap), 32'h0);
`endif
    check("idle_gnt", 32'(gnt), 32'h0);

    // Random traffic against a binary-counter reference model
    do_reset();
    for (int i = 0; i < 4; i++) mbin[i] = '0;
    mlast = 3;
    mwrap = '0;
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      req = 4'($urandom);
      clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
      mgnt = '0;
      if (!rst) begin
        for (int o = 1; o <= 4; o++) begin
          int idx;
          idx = (mlast + o) % 4;
          if (mgnt == 4'h0 && req[idx] && !clr[idx]) mgnt[idx] = 1'b1;
        end
      end
      #1;
      check("rand_gnt", 32'(gnt), 32'(mgnt));
      if (rst) begin
        for (int i = 0; i < 4; i++) mbin[i] = '0;
        mlast = 3;
        mwrap = '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          mwrap[i] = mgnt[i] && (mbin[i] == 4'hF);
          if (clr[i])       mbin[i] = '0;
          else if (mgnt[i]) mbin[i] = mbin[i] + 4'h1;
          if (mgnt[i]) mlast = i;
        end
      end
      tick();
      mptr = {to_gray(mbin[3]), to_gray(mbin[2]), to_gray(mbin[1]), to_gray(mbin[0])};
      check("rand_ptr", 32'(ptr), 32'(mptr));
`ifdef AU_GRAY_PTR_ARB_WRAP_EN
      check("rand_wrap", 32'(wrap), 32'(mwrap));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
